// File: rtl/video_pattern_gen.sv
// Raster video source: de/hsync/vsync timing plus a filled rectangle on a background.
// Rectangle coordinates are captured into shadow registers only between frames.
module video_pattern_gen #(
    parameter int unsigned IMG_W   = 64,
    parameter int unsigned IMG_H   = 64,
    parameter int unsigned H_FP    = 4,
    parameter int unsigned H_SYNC  = 8,
    parameter int unsigned H_BP    = 4,
    parameter int unsigned V_FP    = 2,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 2,
    parameter logic [23:0] OBJ_RGB = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB  = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] x1,
    input  logic [11:0] y1,
    input  logic [11:0] x2,
    input  logic [11:0] y2,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [23:0] pixel_out,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = IMG_W + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = IMG_H + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT      = 12'(IMG_W);
    localparam logic [11:0] H_SYNC_BEG = 12'(IMG_W + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(IMG_W + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT      = 12'(IMG_H);
    localparam logic [11:0] V_SYNC_BEG = 12'(IMG_H + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(IMG_H + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

    logic [11:0] h_cnt, v_cnt;
    logic [11:0] sx1, sy1, sx2, sy2;
    logic        in_active, in_obj, h_last, v_last, h_sync_win, v_sync_win;

    always_comb begin
        h_last     = (h_cnt == H_LAST);
        v_last     = (v_cnt == V_LAST);
        in_active  = en && (h_cnt < H_ACT) && (v_cnt < V_ACT);
        // An inverted shadow pair (sx1>sx2 or sy1>sy2) can never match, so the frame is empty.
        in_obj     = in_active && (sx1 <= h_cnt) && (h_cnt <= sx2)
                               && (sy1 <= v_cnt) && (v_cnt <= sy2);
        h_sync_win = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        v_sync_win = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            frame_start <= 1'b0;
            pixel_out   <= '0;
            // NOTE: shadows reset to an inverted (empty) rectangle, not zero, so no stray pixel at (0,0).
            sx1         <= 12'hFFF;
            sy1         <= 12'hFFF;
            sx2         <= '0;
            sy2         <= '0;
        end else begin
            de          <= in_active;
            hsync       <= en && h_sync_win;
            vsync       <= en && v_sync_win;
            frame_start <= en && (h_cnt == '0) && (v_cnt == '0);

            if (in_obj)         pixel_out <= OBJ_RGB;
            else if (in_active) pixel_out <= BG_RGB;
            else                pixel_out <= '0;

            if (!en) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end

            // Shadows follow the inputs while idle, and otherwise only at the last clock of a frame.
            if (!en || (h_last && v_last)) begin
                sx1 <= x1;
                sy1 <= y1;
                sx2 <= x2;
                sy2 <= y2;
            end
        end
    end

endmodule
